// File: rtl/tdm_pkg.sv
// Shared slot/state definitions for the 4-channel TDM demultiplexer path.
// Slot codes match the select mapping of the upstream 4:1 mux.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;
endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index counter. Priority is clear, then load-to-1, then increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  output logic [SLOT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= SLOT0;
    end else if (clr) begin
      cnt <= SLOT0;
    end else if (load) begin
      cnt <= SLOT1;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: aligns on the sync marker, collects slots 0-2 in
// shadow registers and publishes all four channels together on the slot-3 beat.
//
// state | meaning
// HUNT  | waiting for a sync beat; non-sync beats are dropped silently
// RUN   | aligned; sel is the slot index of the next accepted beat
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic              valid,
  input  logic              sync,
  output logic [WIDTH-1:0]  q0,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  q2,
  output logic [WIDTH-1:0]  q3,
  output logic [SLOT_W-1:0] sel,
  output logic              frame_valid,
  output logic              sync_err
);

  state_t           state;
  logic [WIDTH-1:0] s0, s1, s2;
  logic             cnt_clr, cnt_load, cnt_en;

  // A sync beat always restarts at slot 1; a missing sync at slot 0 drops back to 0.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (valid) begin
      if (sync) begin
        cnt_load = 1'b1;
      end else if (state == RUN) begin
        if (sel == SLOT0) cnt_clr = 1'b1;
        else              cnt_en  = 1'b1;
      end
    end
  end

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .en    (cnt_en),
    .cnt   (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      q0          <= '0;
      q1          <= '0;
      q2          <= '0;
      q3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (valid) begin
        if (sync) begin
          // Early sync discards the partial frame but keeps this beat as slot 0.
          s0    <= din;
          state <= RUN;
          if (state == RUN && sel != SLOT0) sync_err <= 1'b1;
        end else if (state == RUN) begin
          case (sel)
            SLOT0: begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end
            SLOT1: s1 <= din;
            SLOT2: s2 <= din;
            SLOT3: begin
              q0          <= s0;
              q1          <= s1;
              q2          <= s2;
              q3          <= din;
              frame_valid <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: per-beat vector table plus a frame scoreboard.
module tb_tdm_demux_4ch;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         valid;
  logic         sync;
  logic [W-1:0] q0, q1, q2, q3;
  logic [1:0]   sel;
  logic         frame_valid;
  logic         sync_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic         v;
    logic         s;
    logic [W-1:0] d;
    logic [1:0]   sel;
    logic         fv;
    logic         se;
    logic [15:0]  q;
  } vec_t;

  vec_t        tbl[$];
  vec_t        tbl_post[$];
  logic [15:0] sb[$];

  tdm_demux_4ch #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .valid       (valid),
    .sync        (sync),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .sel         (sel),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(logic v, logic s, logic [W-1:0] d, logic [1:0] es,
                               logic fv, logic se, logic [15:0] q);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.sel = es; r.fv = fv; r.se = se; r.q = q;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    valid = t.v;
    sync  = t.s;
    din   = t.d;
    if (t.fv) sb.push_back(t.q);
    @(posedge clk);
    #1;
    check({tag, "_sel"}, {14'd0, sel}, {14'd0, t.sel});
    check({tag, "_fv"}, {15'd0, frame_valid}, {15'd0, t.fv});
    check({tag, "_se"}, {15'd0, sync_err}, {15'd0, t.se});
    check({tag, "_q"}, {q0, q1, q2, q3}, t.q);
    valid = 1'b0;
    sync  = 1'b0;
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (frame_valid && sync_err) begin
      n_cmp++;
      n_err++;
      $display("FAIL pulse_overlap: frame_valid=1 sync_err=1 required not both");
    end
    if (frame_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got frame %h expected no frame", {q0, q1, q2, q3});
      end else begin
        check("sb_frame", {q0, q1, q2, q3}, sb.pop_front());
      end
    end
  end

  initial begin
    // HUNT start: non-sync beats ignored
    tbl.push_back(row(1, 0, 4'hF, 0, 0, 0, 16'h0000));
    tbl.push_back(row(1, 0, 4'hE, 0, 0, 0, 16'h0000));
    tbl.push_back(row(1, 0, 4'hD, 0, 0, 0, 16'h0000));
    // aligned back-to-back frame
    tbl.push_back(row(1, 1, 4'h1, 1, 0, 0, 16'h0000));
    tbl.push_back(row(1, 0, 4'h0, 2, 0, 0, 16'h0000));
    tbl.push_back(row(1, 0, 4'h1, 3, 0, 0, 16'h0000));
    tbl.push_back(row(1, 0, 4'h1, 0, 1, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 0, 0, 0, 16'h1011));
    // gapped frame; sync without valid must be ignored
    tbl.push_back(row(1, 1, 4'hA, 1, 0, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 1, 0, 0, 16'h1011));
    tbl.push_back(row(0, 1, 4'h9, 1, 0, 0, 16'h1011));
    tbl.push_back(row(1, 0, 4'h5, 2, 0, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 2, 0, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 2, 0, 0, 16'h1011));
    tbl.push_back(row(1, 0, 4'hC, 3, 0, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 3, 0, 0, 16'h1011));
    tbl.push_back(row(0, 0, 4'h0, 3, 0, 0, 16'h1011));
    tbl.push_back(row(1, 0, 4'h3, 0, 1, 0, 16'hA5C3));
    tbl.push_back(row(0, 0, 4'h0, 0, 0, 0, 16'hA5C3));
    // early sync at sel=2
    tbl.push_back(row(1, 1, 4'h9, 1, 0, 0, 16'hA5C3));
    tbl.push_back(row(1, 0, 4'h8, 2, 0, 0, 16'hA5C3));
    tbl.push_back(row(1, 1, 4'h7, 1, 0, 1, 16'hA5C3));
    tbl.push_back(row(1, 0, 4'h6, 2, 0, 0, 16'hA5C3));
    tbl.push_back(row(1, 0, 4'h5, 3, 0, 0, 16'hA5C3));
    tbl.push_back(row(1, 0, 4'h4, 0, 1, 0, 16'h7654));
    // missing sync -> HUNT, then resync
    tbl.push_back(row(1, 0, 4'h2, 0, 0, 1, 16'h7654));
    tbl.push_back(row(1, 0, 4'h3, 0, 0, 0, 16'h7654));
    tbl.push_back(row(1, 0, 4'h1, 0, 0, 0, 16'h7654));
    tbl.push_back(row(1, 1, 4'hB, 1, 0, 0, 16'h7654));
    tbl.push_back(row(1, 0, 4'hC, 2, 0, 0, 16'h7654));
    tbl.push_back(row(1, 0, 4'hD, 3, 0, 0, 16'h7654));
    tbl.push_back(row(1, 0, 4'hE, 0, 1, 0, 16'hBCDE));
    // partial frame that reset will cut short
    tbl.push_back(row(1, 1, 4'h1, 1, 0, 0, 16'hBCDE));
    tbl.push_back(row(1, 0, 4'h2, 2, 0, 0, 16'hBCDE));
    tbl.push_back(row(1, 0, 4'h3, 3, 0, 0, 16'hBCDE));
    // full frame after reset release
    tbl_post.push_back(row(1, 1, 4'h4, 1, 0, 0, 16'h0000));
    tbl_post.push_back(row(1, 0, 4'h5, 2, 0, 0, 16'h0000));
    tbl_post.push_back(row(1, 0, 4'h6, 3, 0, 0, 16'h0000));
    tbl_post.push_back(row(1, 0, 4'h7, 0, 1, 0, 16'h4567));
    tbl_post.push_back(row(0, 0, 4'h0, 0, 0, 0, 16'h4567));

    reset = 1'b1;
    valid = 1'b0;
    sync  = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", {q0, q1, q2, q3}, 16'h0000);
    check("rst_sel", {14'd0, sel}, 16'd0);
    check("rst_fv", {15'd0, frame_valid}, 16'd0);
    check("rst_se", {15'd0, sync_err}, 16'd0);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // asynchronous reset between slot 2 and slot 3
    #2 reset = 1'b1;
    #1;
    check("midrst_q", {q0, q1, q2, q3}, 16'h0000);
    check("midrst_sel", {14'd0, sel}, 16'd0);
    check("midrst_fv", {15'd0, frame_valid}, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl_post[i]) apply(tbl_post[i], $sformatf("post%0d", i));

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive end of the 4:1 multiplexer path. It accepts one word per valid beat from a serialized TDM stream, with a sync marker on slot 0. It steers slots 0–3 into four registered channel outputs, which update atomically once per complete frame. It sits downstream of the mux/serializer and detects and recovers from frame-alignment errors.

## Interface
Parameters:
- WIDTH, 1, bit width of each channel word

Ports:
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-high reset
- Din  input  WIDTH  serialized channel word for the current slot
- Valid  input  1  Din/Sync qualifier; a beat is accepted on a rising Clk edge with Valid=1
- Sync  input  1  frame marker; Valid&&Sync marks the beat as slot 0
- Q0  output  WIDTH  channel 0 word (slot 0, select code 00)
- Q1  output  WIDTH  channel 1 word (slot 1, select code 01)
- Q2  output  WIDTH  channel 2 word (slot 2, select code 10)
- Q3  output  WIDTH  channel 3 word (slot 3, select code 11)
- Sel  output  2  slot index expected for the next accepted beat
- FrameValid  output  1  one-cycle pulse; Q0..Q3 hold a newly completed frame
- SyncErr  output  1  one-cycle pulse; frame alignment violated

## Operation
- Reset (async, active-high) forces:
  - state HUNT, Sel=0
  - Q0..Q3=0, shadow registers S0..S2=0
  - FrameValid=0, SyncErr=0
- State HUNT:
  - Valid&&!Sync beats are ignored, with no error.
  - Valid&&Sync: S0<=Din, Sel<=1, go to RUN.
- State RUN, on an accepted beat:
  - Sel=0 and Sync=1: S0<=Din, Sel<=1.
  - Sel=0 and Sync=0: SyncErr pulse, return to HUNT, Sel<=0, beat discarded.
  - Sel=1 or 2, Sync=0: S[Sel]<=Din, Sel<=Sel+1.
  - Sel=3, Sync=0 (frame complete):
    - Q0<=S0, Q1<=S1, Q2<=S2, Q3<=Din, all on the same edge.
    - FrameValid pulses; Sel wraps to 0; stay in RUN.
  - Sel=1..3 with Sync=1 (early sync):
    - SyncErr pulses; partial frame discarded; Q unchanged.
    - The beat is taken as a new slot 0: S0<=Din, Sel<=1, stay in RUN.
- Valid=0: no state, Sel or shadow change; FrameValid and SyncErr are 0.
- Q0..Q3 change only on frame completion and hold between frames. A partial frame never reaches Q.
- FrameValid and SyncErr are never high in the same cycle.

## Timing
- All outputs are registered off Clk; no combinational input-to-output path.
- Latency: Q and FrameValid update on the same edge that accepts the slot-3 beat. Both are visible one cycle after that beat is presented.
- Minimum frame period is 4 cycles (back-to-back Valid). Gaps of any length between beats are allowed; Sel holds during gaps.
- FrameValid and SyncErr are each high for exactly one cycle per event.
- Reset asserted mid-frame takes effect immediately (asynchronous). The in-flight frame is lost and Q clears to 0.
- After Reset deasserts, the first accepted beat is evaluated in HUNT.

## Structure
- Shared package tdm_pkg holds:
  - NUM_SLOTS=4, SLOT_W=2
  - state encoding HUNT=1'b0, RUN=1'b1
  - slot codes SLOT0..SLOT3 = 2'd0..2'd3, matching the 4:1 mux select mapping
- Sub-module tdm_slot_counter: 2-bit wrapping counter with async active-high Reset, synchronous load-to-1 (on sync), enable (increment), and clear.
- The top level holds the FSM, the shadow registers and the output registers.

## Test plan
- Reset then aligned frame: Sync on beat 1; Din=1,0,1,1 over 4 consecutive cycles (WIDTH=1) -> Q0..Q3=1,0,1,1 one cycle after the last beat; FrameValid high exactly 1 cycle; SyncErr=0.
- Gapped frame: WIDTH=4; beats A,5,C,3 with 2 idle cycles between each -> Sel steps 1,2,3,0 and holds during gaps; Q0..Q3=A,5,C,3; single FrameValid pulse.
- Early sync: slots 0,1 sent (9,8), then Sync with Din=7 at Sel=2 -> SyncErr pulse; Q unchanged; Sel=1; the next 3 beats (6,5,4) complete a frame with Q0..Q3=7,6,5,4.
- Missing sync: after a complete frame, a Valid beat with Sync=0 -> SyncErr pulse; state HUNT; following non-sync beats ignored; the next Sync restarts capture.
- HUNT start: 3 non-sync beats after reset -> no FrameValid, no SyncErr, Q stays 0.
- Reset mid-frame: assert Reset between slot 2 and slot 3 -> Q0..Q3=0, Sel=0, no FrameValid. A full frame after release is captured correctly.
